timer_controle: RTL and testbench
=================================

# timer_controle

Countdown-timer controller for the three-digit M:SS display (0:00–9:59).
- Accepts keypad digit entry and start/stop/clear commands.
- Generates the one-second time base from the system clock.
- Drives the BCD digit buses consumed by the 7-segment decoder: Minutos, DezenaSeg, Segundos.
- Sits between the keypad/button front end and the display decoder, and owns the only copy of the timer value.

## Interface
- TICKS_PER_SEC, default 50_000_000: clock cycles per displayed second; minimum 2.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- digit_valid  input  1  one-cycle strobe: digit_in is a keypad press.
- digit_in  input  4  BCD keypad digit; values above 9 are ignored.
- start  input  1  start/resume command (level sampled per cycle).
- stop  input  1  pause command.
- clear  input  1  abort; zero the timer.
- Minutos  output  4  BCD minutes, 0–9.
- DezenaSeg  output  4  BCD tens of seconds, 0–5.
- Segundos  output  4  BCD seconds, 0–9.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the count reaches 0:00.
- alarm  output  1  high while in DONE.

## Operation
- Reset (async, rst_n=0):
  - state IDLE; all digits 0; prescaler 0.
  - running=0, done=0, alarm=0.
- States: IDLE (entry), RUN, PAUSE, DONE.
- Command priority per cycle: clear > stop > start > digit_valid. Only the highest-priority active command acts.
- clear, any state: → IDLE; digits 0; prescaler 0.
- IDLE:
  - Digit entry: a valid digit d shifts left. New state is Minutos←DezenaSeg, DezenaSeg←Segundos, Segundos←d; the old Minutos is discarded.
  - If the shifted DezenaSeg would exceed 5, the press is rejected and nothing changes.
  - If digit_in > 9, the press is ignored.
  - start with value ≠ 0:00 → RUN, prescaler 0.
  - start with 0:00 is ignored.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC−1 and wraps.
  - On the wrap cycle the value decrements by one second with BCD borrow:
    - Segundos 0→9 borrows from DezenaSeg.
    - DezenaSeg 0→5 borrows from Minutos.
  - stop → PAUSE. Digits and prescaler are held, and a pending wrap in the same cycle is not applied.
  - digit_valid is ignored.
- PAUSE:
  - start → RUN. The prescaler resumes from its held value.
  - digit_valid is ignored.
- DONE:
  - Reached on the edge that loads 0:00 from a decrement.
  - digit_valid → IDLE, with the digits set to 0:0d (first digit of a new entry).
  - start and stop are ignored.
- Digits never leave their BCD ranges (Minutos/Segundos 0–9, DezenaSeg 0–5) in any state.

## Timing
- All outputs are registered and change only on a clk rising edge, or asynchronously on reset.
- Digit entry: the digits update on the edge that samples digit_valid, so they are visible one cycle after the strobe.
- Start from IDLE: the first decrement happens on the TICKS_PER_SEC-th rising edge after the edge that sampled start. Each further decrement follows every TICKS_PER_SEC cycles.
- running goes high on the edge entering RUN and low on the edge leaving RUN.
- done is high for exactly the one cycle following the edge that loads 0:00. alarm rises on that same edge.
- Pause/resume: total RUN cycles between decrements is always exactly TICKS_PER_SEC. Cycles spent in PAUSE are not counted.
- Simultaneous stop with a wrap: stop wins. The prescaler holds at TICKS_PER_SEC−1 and the decrement occurs on the first RUN cycle after resume.
- Reset asserted mid-RUN: the outputs clear immediately, without waiting for clk.

## Test plan
- Entry: press 1, 3, 0 → Minutos=1, DezenaSeg=3, Segundos=0 (1:30). A further 0 → 3:00. Press 9 with the digits at 0:07 → rejected (would give 0:79); the display stays 0:07.
- Countdown, TICKS_PER_SEC=4: load 1:00, start → running=1. After 4 cycles the display is 0:59; after 8 cycles it is 0:58. Check the borrow chain and BCD ranges throughout.
- Completion, TICKS_PER_SEC=4: load 0:02, start → 0:01 at cycle 4, 0:00 at cycle 8. done is high exactly one cycle, alarm stays 1, running=0. A digit press of 5 → IDLE with the display 0:05 and alarm=0.
- Pause: in RUN at 0:30 with the prescaler at 2 (of 4), assert stop for 10 cycles, then start. The next decrement comes 2 cycles after resume; the display shows 0:29.
- Priority and ignores:
  - start at 0:00 → remains IDLE.
  - clear+stop+start in the same cycle during RUN → IDLE, display 0:00.
  - digit_in=12 with a strobe → no change.
- Async reset: drop rst_n between clock edges during RUN at 4:15 → all outputs are 0 immediately, state IDLE. Release, then start → ignored (value 0:00).

Source files
------------

// File: rtl/timer_controle.sv
// Countdown-timer controller for an M:SS display (0:00-9:59): keypad entry,
// start/stop/clear commands, one-second prescaler and BCD countdown with borrow.
module timer_controle #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] Minutos,
  output logic [3:0] DezenaSeg,
  output logic [3:0] Segundos,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic [1:0] fsm_state
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [3:0]    min_q, dez_q, seg_q;
  logic [3:0]    min_d, dez_d, seg_d;
  logic          done_q, done_d;

  logic [3:0] dec_min, dec_dez, dec_seg;
  logic       dec_zero, value_zero, digit_ok;

  // One-second decrement with BCD borrow; never evaluated at 0:00 in RUN.
  always_comb begin
    dec_min = min_q;
    dec_dez = dez_q;
    dec_seg = seg_q - 4'd1;
    if (seg_q == 4'd0) begin
      dec_seg = 4'd9;
      if (dez_q == 4'd0) begin
        dec_dez = 4'd5;
        dec_min = min_q - 4'd1;
      end else begin
        dec_dez = dez_q - 4'd1;
      end
    end
  end

  assign dec_zero   = (dec_min == 4'd0) && (dec_dez == 4'd0) && (dec_seg == 4'd0);
  assign value_zero = (min_q == 4'd0) && (dez_q == 4'd0) && (seg_q == 4'd0);
  assign digit_ok   = digit_valid && (digit_in <= 4'd9);

  always_comb begin
    state_d = state;
    presc_d = presc;
    min_d   = min_q;
    dez_d   = dez_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      min_d   = 4'd0;
      dez_d   = 4'd0;
      seg_d   = 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // An active stop still outranks start/digit, even though it does nothing here.
          if (stop) begin
            state_d = S_IDLE;
          end else if (start) begin
            if (!value_zero) begin
              state_d = S_RUN;
              presc_d = '0;
            end
          end else if (digit_ok && (seg_q <= 4'd5)) begin
            min_d = dez_q;
            dez_d = seg_q;
            seg_d = digit_in;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (presc == LAST) begin
            presc_d = '0;
            min_d   = dec_min;
            dez_d   = dec_dez;
            seg_d   = dec_seg;
            if (dec_zero) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (!stop && start) state_d = S_RUN;
        end
        S_DONE: begin
          if (!stop && !start && digit_ok) begin
            state_d = S_IDLE;
            min_d   = 4'd0;
            dez_d   = 4'd0;
            seg_d   = digit_in;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      presc  <= '0;
      min_q  <= 4'd0;
      dez_q  <= 4'd0;
      seg_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      presc  <= presc_d;
      min_q  <= min_d;
      dez_q  <= dez_d;
      seg_q  <= seg_d;
      done_q <= done_d;
    end
  end

  assign Minutos   = min_q;
  assign DezenaSeg = dez_q;
  assign Segundos  = seg_q;
  assign running   = (state == S_RUN);
  assign alarm     = (state == S_DONE);
  assign done      = done_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_timer_controle.sv
// Directed bench for timer_controle: stimulus pushes expected snapshots,
// a negedge monitor pops and compares them against the live outputs.
module tb_timer_controle;

  localparam int TPS = 4;
  localparam int W   = 17;

  logic       clk;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] Minutos;
  logic [3:0] DezenaSeg;
  logic [3:0] Segundos;
  logic       running;
  logic       done;
  logic       alarm;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  timer_controle #(.TICKS_PER_SEC(TPS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit_in    (digit_in),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .Minutos     (Minutos),
    .DezenaSeg   (DezenaSeg),
    .Segundos    (Segundos),
    .running     (running),
    .done        (done),
    .alarm       (alarm),
    .fsm_state   (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot layout: {state, running, done, alarm, M, DS, S}
  function automatic logic [W-1:0] snap(input logic [1:0] st, input logic r,
                                        input logic d, input logic a,
                                        input logic [3:0] m, input logic [3:0] dz,
                                        input logic [3:0] s);
    return {st, r, d, a, m, dz, s};
  endfunction

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic press(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    step(1);
    digit_valid = 1'b0;
    digit_in    = 4'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {fsm_state, running, done, alarm, Minutos, DezenaSeg, Segundos};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, e, $time);
      end
      checks++;
      if (Minutos > 4'd9 || DezenaSeg > 4'd5 || Segundos > 4'd9) begin
        failures++;
        $display("FAIL bcd_range_%s actual=%0d:%0d%0d required=M<=9,DS<=5,S<=9",
                 nm, Minutos, DezenaSeg, Segundos);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout actual=not_finished required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    step(2);
    expect_snap("reset", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd0));
    step(1);
    rst_n = 1'b1;
    step(1);

    // Entry
    press(4'd1);
    expect_snap("entry_1", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd1));
    press(4'd3);
    press(4'd0);
    expect_snap("entry_130", snap(2'd0, 0, 0, 0, 4'd1, 4'd3, 4'd0));
    press(4'd0);
    expect_snap("entry_300", snap(2'd0, 0, 0, 0, 4'd3, 4'd0, 4'd0));
    pulse_clear();
    expect_snap("clear_idle", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd0));
    press(4'd0);
    press(4'd7);
    expect_snap("entry_007", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd7));
    press(4'd9);
    expect_snap("reject_079", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd7));
    press(4'd12);
    expect_snap("ignore_gt9", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd7));

    // start at 0:00 is ignored
    pulse_clear();
    pulse_start();
    expect_snap("start_zero", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd0));

    // Countdown 1:00 -> 0:59 -> 0:58
    press(4'd1); press(4'd0); press(4'd0);
    expect_snap("load_100", snap(2'd0, 0, 0, 0, 4'd1, 4'd0, 4'd0));
    pulse_start();
    expect_snap("run_start", snap(2'd1, 1, 0, 0, 4'd1, 4'd0, 4'd0));
    step(3);
    expect_snap("run_pre_wrap", snap(2'd1, 1, 0, 0, 4'd1, 4'd0, 4'd0));
    step(1);
    expect_snap("run_059", snap(2'd1, 1, 0, 0, 4'd0, 4'd5, 4'd9));
    step(4);
    expect_snap("run_058", snap(2'd1, 1, 0, 0, 4'd0, 4'd5, 4'd8));

    // clear + stop + start together during RUN
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    step(1);
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    expect_snap("prio_clear", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd0));

    // Completion from 0:02
    press(4'd2);
    pulse_start();
    step(3);
    expect_snap("cmp_002", snap(2'd1, 1, 0, 0, 4'd0, 4'd0, 4'd2));
    step(1);
    expect_snap("cmp_001", snap(2'd1, 1, 0, 0, 4'd0, 4'd0, 4'd1));
    step(3);
    expect_snap("cmp_001_hold", snap(2'd1, 1, 0, 0, 4'd0, 4'd0, 4'd1));
    step(1);
    expect_snap("cmp_done", snap(2'd3, 0, 1, 1, 4'd0, 4'd0, 4'd0));
    step(1);
    expect_snap("cmp_done_pulse_end", snap(2'd3, 0, 0, 1, 4'd0, 4'd0, 4'd0));
    pulse_start();
    expect_snap("done_ignore_start", snap(2'd3, 0, 0, 1, 4'd0, 4'd0, 4'd0));
    press(4'd5);
    expect_snap("done_digit", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd5));

    // Pause at prescaler 2, resume, decrement 2 cycles later
    pulse_clear();
    press(4'd3); press(4'd0);
    pulse_start();
    step(2);
    stop = 1'b1;
    step(10);
    expect_snap("paused", snap(2'd2, 0, 0, 0, 4'd0, 4'd3, 4'd0));
    stop = 1'b0;
    press(4'd4);
    expect_snap("pause_ignore_digit", snap(2'd2, 0, 0, 0, 4'd0, 4'd3, 4'd0));
    pulse_start();
    expect_snap("resume", snap(2'd1, 1, 0, 0, 4'd0, 4'd3, 4'd0));
    step(1);
    expect_snap("resume_plus1", snap(2'd1, 1, 0, 0, 4'd0, 4'd3, 4'd0));
    step(1);
    expect_snap("resume_029", snap(2'd1, 1, 0, 0, 4'd0, 4'd2, 4'd9));

    // stop coinciding with a wrap: decrement deferred to first RUN cycle after resume
    step(3);
    pulse_stop();
    expect_snap("stop_wrap_hold", snap(2'd2, 0, 0, 0, 4'd0, 4'd2, 4'd9));
    pulse_start();
    expect_snap("stop_wrap_resume", snap(2'd1, 1, 0, 0, 4'd0, 4'd2, 4'd9));
    step(1);
    expect_snap("stop_wrap_028", snap(2'd1, 1, 0, 0, 4'd0, 4'd2, 4'd8));

    // Async reset mid-RUN at 4:15
    pulse_clear();
    press(4'd4); press(4'd1); press(4'd5);
    pulse_start();
    step(2);
    expect_snap("run_415", snap(2'd1, 1, 0, 0, 4'd4, 4'd1, 4'd5));
    step(1);
    #1 rst_n = 1'b0;
    expect_snap("async_reset", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd0));
    step(1);
    rst_n = 1'b1;
    pulse_start();
    expect_snap("post_reset_start", snap(2'd0, 0, 0, 0, 4'd0, 4'd0, 4'd0));

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
